// File: rtl/codec_spi_arbiter_if.sv
// Requester and SPI-master side bundle for the codec SPI arbiter.
// master = arbiter side, slave = requesters plus SPI master side.
interface codec_spi_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]    req;
  logic [16*NREQ-1:0] req_word;
  logic [NREQ-1:0]    gnt;
  logic               busy;
  logic [15:0]        spi_data;
  logic               spi_trg;
  logic               spi_rdy;
  logic               cs;

  modport master (
    input  req,
    input  req_word,
    input  spi_rdy,
    output gnt,
    output busy,
    output spi_data,
    output spi_trg,
    output cs
  );

  modport slave (
    output req,
    output req_word,
    output spi_rdy,
    input  gnt,
    input  busy,
    input  spi_data,
    input  spi_trg,
    input  cs
  );
endinterface

// File: rtl/codec_spi_arbiter.sv
// Round-robin arbiter sharing the codec control SPI master.
// Sequences trigger/ready handshake, cs latch pulse and shadow regs.
module codec_spi_arbiter #(
  parameter int NREQ         = 2,
  parameter int LATCH_CYCLES = 1
) (
  input  logic                clk,
  input  logic                reset,
  codec_spi_arbiter_if.master bus,
  input  logic [3:0]          rd_addr,
  output logic [8:0]          rd_data,
  output logic [7:0]          wr_count
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] TRIG   = 3'd1;
  localparam logic [2:0] WAITLO = 3'd2;
  localparam logic [2:0] WAITHI = 3'd3;
  localparam logic [2:0] LATCH  = 3'd4;
  localparam logic [2:0] GAP    = 3'd5;

  localparam logic [3:0] TO_LAST  = 4'd3;
  localparam logic [3:0] LAT_LAST = 4'(LATCH_CYCLES - 1);

  logic [2:0]      state;
  logic [3:0]      cnt;
  logic [PW-1:0]   ptr;
  logic [8:0]      shadow [16];

  logic            sel_hit;
  logic [PW-1:0]   sel_idx;
  logic [NREQ-1:0] sel_oh;
  logic [15:0]     sel_word;
  logic [PW-1:0]   ptr_nxt;

  logic            shadow_we;
  logic [6:0]      waddr;
  logic [8:0]      wdata;

  // First pending requester at or above the pointer, else lowest one.
  always_comb begin
    sel_hit  = 1'b0;
    sel_idx  = '0;
    sel_oh   = '0;
    sel_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!sel_hit && bus.req[i] && i >= int'(ptr)) begin
        sel_hit   = 1'b1;
        sel_idx   = PW'(i);
        sel_oh[i] = 1'b1;
        sel_word  = bus.req_word[16*i +: 16];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!sel_hit && bus.req[i]) begin
        sel_hit   = 1'b1;
        sel_idx   = PW'(i);
        sel_oh[i] = 1'b1;
        sel_word  = bus.req_word[16*i +: 16];
      end
    end
  end

  assign ptr_nxt = (sel_idx == PW'(NREQ - 1)) ? '0
                 : sel_idx + PW'(1);

  assign waddr     = bus.spi_data[15:9];
  assign wdata     = bus.spi_data[8:0];
  assign shadow_we = (state == LATCH) && (cnt == LAT_LAST);
  assign rd_data   = shadow[rd_addr];

  // Transfer sequencer: grant, trigger, ready handshake, cs latch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      ptr          <= '0;
      bus.gnt      <= '0;
      bus.busy     <= 1'b0;
      bus.spi_data <= '0;
      bus.spi_trg  <= 1'b0;
      bus.cs       <= 1'b1;
      wr_count     <= '0;
    end else begin
      bus.gnt     <= '0;
      bus.spi_trg <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (bus.spi_rdy && sel_hit) begin
            bus.spi_data <= sel_word;
            bus.gnt      <= sel_oh;
            bus.busy     <= 1'b1;
            ptr          <= ptr_nxt;
            state        <= TRIG;
          end
        end
        TRIG: begin
          bus.spi_trg <= 1'b1;
          cnt         <= '0;
          state       <= WAITLO;
        end
        WAITLO: begin
          if (!bus.spi_rdy || cnt == TO_LAST) begin
            cnt   <= '0;
            state <= WAITHI;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        WAITHI: begin
          if (bus.spi_rdy) begin
            bus.cs <= 1'b0;
            cnt    <= '0;
            state  <= LATCH;
          end
        end
        LATCH: begin
          if (cnt == LAT_LAST) begin
            bus.cs   <= 1'b1;
            wr_count <= wr_count + 8'd1;
            cnt      <= '0;
            state    <= GAP;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        GAP: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.cs   <= 1'b1;
          bus.busy <= 1'b0;
          cnt      <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // Shadow copy of the write-only codec registers; addr 15 clears all.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int a = 0; a < 16; a++) shadow[a] <= '0;
    end else if (shadow_we) begin
      unique case (1'b1)
        (waddr < 7'd15): shadow[waddr[3:0]] <= wdata;
        (waddr == 7'd15): begin
          for (int a = 0; a < 16; a++) shadow[a] <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_codec_spi_arbiter.sv
// Scoreboard bench for codec_spi_arbiter with a simple SPI master model.
// Stimulus pushes expected grants; a negedge monitor checks them.
module tb_codec_spi_arbiter;
  localparam int NREQ         = 2;
  localparam int LATCH_CYCLES = 1;
  localparam int WW           = 16 * NREQ;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] rd_addr = '0;
  logic [8:0] rd_data;
  logic [7:0] wr_count;

  codec_spi_arbiter_if #(.NREQ(NREQ)) bus ();

  codec_spi_arbiter #(
    .NREQ(NREQ),
    .LATCH_CYCLES(LATCH_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [15:0] word;
  } exp_t;

  exp_t sb[$];
  int   checks  = 0;
  int   fails   = 0;
  int   cyc     = 0;
  bit   fast    = 1'b0;
  int   mcnt    = 0;
  int   exp_wr  = 0;
  int   gnt_cyc = 0;
  int   low_len = 0;
  bit   prev_busy = 1'b0;
  bit   prev_gnt  = 1'b0;
  bit   cs_prev   = 1'b1;
  exp_t e;

  task automatic check_eq(input string nm, input logic [31:0] act,
                          input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit bit_of(input logic [NREQ-1:0] v, input int i);
    logic [NREQ-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // SPI master model: rdy low 16 cycles after trg, unless fast.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.spi_rdy <= 1'b1;
      mcnt        <= 0;
    end else if (!fast && bus.spi_trg) begin
      bus.spi_rdy <= 1'b0;
      mcnt        <= 16;
    end else if (mcnt == 1) begin
      bus.spi_rdy <= 1'b1;
      mcnt        <= 0;
    end else if (mcnt > 1) begin
      mcnt <= mcnt - 1;
    end
  end

  // Monitor: grants against scoreboard, trg timing, cs pulse, count.
  always @(negedge clk) begin
    if (!reset) begin
      sb.delete();
      exp_wr    = 0;
      low_len   = 0;
      prev_busy = 1'b0;
      prev_gnt  = 1'b0;
      cs_prev   = 1'b1;
    end else begin
      if (|bus.gnt) begin
        check_eq("gnt_after_idle", 32'(prev_busy), 32'(0));
        if (sb.size() == 0) begin
          check_eq("gnt_unexpected", 32'(bus.gnt), 32'(0));
        end else begin
          e = sb.pop_front();
          check_eq("gnt_vec", 32'(bus.gnt), 32'(NREQ'(1) << e.idx));
          check_eq("spi_data", 32'(bus.spi_data), 32'(e.word));
        end
        gnt_cyc = cyc;
      end
      if (bus.spi_trg) check_eq("trg_after_gnt", 32'(prev_gnt), 32'(1));
      if (!bus.cs) begin
        if (cs_prev)
          check_eq("cs_delay", 32'(cyc - gnt_cyc), fast ? 32'(6) : 32'(19));
        low_len++;
      end else if (!cs_prev) begin
        exp_wr = (exp_wr + 1) % 256;
        check_eq("cs_low_len", 32'(low_len), 32'(LATCH_CYCLES));
        check_eq("wr_count", 32'(wr_count), 32'(exp_wr));
        low_len = 0;
      end
      prev_busy = bus.busy;
      prev_gnt  = |bus.gnt;
      cs_prev   = bus.cs;
    end
  end

  task automatic set_req(input int idx, input logic [15:0] w);
    bus.req_word = (bus.req_word & ~(WW'(16'hFFFF) << (16 * idx)))
                 | (WW'(w) << (16 * idx));
    bus.req = bus.req | (NREQ'(1) << idx);
  endtask

  task automatic drop(input int idx);
    bus.req = bus.req & ~(NREQ'(1) << idx);
  endtask

  task automatic push_exp(input int idx, input logic [15:0] w);
    exp_t x;
    x.idx  = idx;
    x.word = w;
    sb.push_back(x);
  endtask

  task automatic wait_gnt(input int idx);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bit_of(bus.gnt, idx) && n < 300);
    check_eq("gnt_seen", 32'(bit_of(bus.gnt, idx)), 32'(1));
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy && n < 300);
    check_eq("busy_clear", 32'(bus.busy), 32'(0));
  endtask

  task automatic do_write(input int idx, input logic [15:0] w);
    set_req(idx, w);
    push_exp(idx, w);
    wait_gnt(idx);
    drop(idx);
    wait_idle();
  endtask

  task automatic rd(input logic [3:0] a, input logic [8:0] x,
                    input string nm);
    rd_addr = a;
    #1;
    check_eq(nm, 32'(rd_data), 32'(x));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
  endtask

  initial begin
    int n;
    bus.req      = '0;
    bus.req_word = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_gnt", 32'(bus.gnt), 32'(0));
    check_eq("rst_busy", 32'(bus.busy), 32'(0));
    check_eq("rst_trg", 32'(bus.spi_trg), 32'(0));
    check_eq("rst_spi_data", 32'(bus.spi_data), 32'(0));
    check_eq("rst_cs", 32'(bus.cs), 32'(1));
    check_eq("rst_wr_count", 32'(wr_count), 32'(0));
    rd(4'd9, 9'h000, "rst_shadow9");
    #2 reset = 1'b1;

    fast = 1'b0;
    do_write(0, 16'h1201);
    rd(4'd9, 9'h001, "single_shadow9");
    check_eq("single_wr_count", 32'(wr_count), 32'(1));

    do_reset();
    set_req(0, 16'h0211);
    set_req(1, 16'h0822);
    push_exp(0, 16'h0211);
    push_exp(1, 16'h0822);
    push_exp(0, 16'h0211);
    push_exp(1, 16'h0822);
    wait_gnt(0);
    wait_gnt(1);
    wait_gnt(0);
    wait_gnt(1);
    bus.req = '0;
    wait_idle();
    rd(4'd1, 9'h011, "rr_shadow1");
    rd(4'd4, 9'h022, "rr_shadow4");
    check_eq("rr_wr_count", 32'(wr_count), 32'(4));

    do_write(0, 16'h056E);
    rd(4'd2, 9'h16E, "sh_write2");
    do_write(0, 16'h1E00);
    rd(4'd2, 9'h000, "sh_clear2");
    rd(4'd1, 9'h000, "sh_clear1");
    do_write(0, 16'h0AAB);
    do_write(1, 16'h41FF);
    rd(4'd5, 9'h0AB, "sh_hi_addr5");
    rd(4'd0, 9'h000, "sh_hi_addr0");

    fast = 1'b1;
    do_write(0, 16'h0A33);
    rd(4'd5, 9'h033, "fast_shadow5");
    set_req(0, 16'h0C44);
    push_exp(0, 16'h0C44);
    wait_gnt(0);
    drop(0);
    set_req(1, 16'h0E55);
    push_exp(1, 16'h0E55);
    wait_gnt(1);
    drop(1);
    wait_idle();
    rd(4'd6, 9'h044, "busy_req_shadow6");
    rd(4'd7, 9'h055, "busy_req_shadow7");

    set_req(0, 16'h1066);
    push_exp(0, 16'h1066);
    wait_gnt(0);
    drop(0);
    set_req(1, 16'h1277);
    repeat (3) @(negedge clk);
    drop(1);
    wait_idle();
    repeat (20) @(negedge clk);
    check_eq("withdraw_wr_count", 32'(wr_count), 32'(12));
    check_eq("withdraw_busy", 32'(bus.busy), 32'(0));
    rd(4'd9, 9'h000, "withdraw_shadow9");
    rd(4'd8, 9'h066, "withdraw_shadow8");

    fast = 1'b0;
    set_req(0, 16'h0655);
    push_exp(0, 16'h0655);
    wait_gnt(0);
    drop(0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.cs && n < 300);
    check_eq("cs_low_seen", 32'(bus.cs), 32'(0));
    #2 reset = 1'b0;
    #1;
    check_eq("midrst_cs", 32'(bus.cs), 32'(1));
    check_eq("midrst_wr_count", 32'(wr_count), 32'(0));
    check_eq("midrst_busy", 32'(bus.busy), 32'(0));
    rd(4'd5, 9'h000, "midrst_shadow5");
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    do_write(1, 16'h0388);
    rd(4'd1, 9'h188, "post_rst_shadow1");
    check_eq("post_rst_wr_count", 32'(wr_count), 32'(1));

    fast = 1'b1;
    for (int k = 0; k < 255; k++) do_write(0, 16'h2001);
    check_eq("wrap_wr_count", 32'(wr_count), 32'(0));
    rd(4'd1, 9'h188, "wrap_shadow1");
    check_eq("sb_empty", 32'(sb.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/codec_spi_arbiter.md
Name: codec_spi_arbiter

Overview:
- Shares the codec control SPI master between NREQ requesters: boot configurator, runtime volume/mute control, and similar sources.
- Each requester posts one 16-bit control word, {addr[6:0], data[8:0]}.
- The block grants requesters round-robin, sequences the SPI master handshake and generates the codec CS latch pulse.
- The codec registers are write-only, so the block keeps a shadow copy of every written register for readback.

Parameters:
- NREQ, 2, number of requesters (1..8); index 0 is the boot configurator.
- LATCH_CYCLES, 1, cycles cs is held low after each shifted word (1..15).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester write request, level.
- req_word  in  16*NREQ  requester i word in bits [16i+15:16i], {addr7, data9}.
- gnt  out  NREQ  one-cycle pulse when requester i's word is captured.
- busy  out  1  high from capture until the end of the GAP state.
- spi_data  out  16  word to the SPI master DATA input.
- spi_trg  out  1  one-cycle start pulse to the SPI master TRG input.
- spi_rdy  in  1  SPI master RDY: high when idle.
- cs  out  1  codec chip select; idles high, low pulse latches the word.
- rd_addr  in  4  shadow readback address.
- rd_data  out  9  shadow register contents, combinational from rd_addr.
- wr_count  out  8  number of completed writes, wraps 255 -> 0.

Behaviour:
- Reset (reset=0, asynchronous) drives:
  - state=IDLE; gnt=0, busy=0, spi_trg=0, spi_data=0, cs=1, wr_count=0.
  - all 16 shadow entries = 0; round-robin pointer = 0.
- IDLE:
  - Entered when spi_rdy=1 and at least one req bit is set.
  - Selects the first set req at or after the pointer, scanning upward with wrap.
  - Same edge: spi_data <= selected word, gnt[i]=1 for one cycle, busy=1, pointer <= i+1 (mod NREQ); go to TRIG.
  - If spi_rdy=0, stays in IDLE and issues no grant.
- TRIG: spi_trg=1 for exactly one cycle; go to WAITLO.
- WAITLO: waits for spi_rdy=0; go to WAITHI.
  - Timeout: if spi_rdy is still 1 after 4 cycles, treat the transfer as started and go to WAITHI. This protects against a master that completes within the trigger cycle.
- WAITHI: waits for spi_rdy=1; go to LATCH.
- LATCH:
  - cs=0 for LATCH_CYCLES cycles.
  - On the final LATCH cycle: shadow update, wr_count+1.
  - Go to GAP.
- GAP: cs=1, one cycle; busy=0 on exit; go to IDLE. Minimum spacing between grants is therefore 3+LATCH_CYCLES+SPI time cycles.
- Shadow update on the final LATCH cycle:
  - addr < 15: shadow[addr] <= data.
  - addr == 15 (codec reset register): all shadow entries <= 0.
  - addr > 15: shadow unchanged; the word is still sent.
- Requester protocol:
  - Hold req and req_word stable until gnt.
  - Deassert req in the gnt cycle or the cycle after; a requester still holding req re-enters arbitration after GAP.
  - Dropping req before gnt withdraws the request with no side effect.
- Simultaneous events:
  - Arbitration is evaluated only in IDLE; requests arriving mid-transfer wait.
  - Several requesters pending: served strictly round-robin, so none waits more than NREQ-1 transfers.
- Reset mid-transfer: cs returns to 1 immediately and the word is abandoned. The SPI master has its own reset and is not driven by this block.
- req_word changes after gnt do not affect spi_data.

Test Plan:
- Single request: reset released, req=01, word 16'h1201 (addr 0x09, data 0x001), master RDY low 16 cycles.
  - Expect gnt[0] one cycle, spi_trg one cycle later, spi_data=16'h1201.
  - Expect cs low LATCH_CYCLES after RDY rises; rd_addr=9 gives rd_data=9'h001; wr_count=1.
- Round-robin: req=11 held continuously.
  - Expect grant order 0,1,0,1 across four transfers.
  - Expect no back-to-back grants to the same requester while the other is pending.
- Shadow reset:
  - Write addr 0x02 data 9'h16E, then addr 0x0F data 0: rd_data at rd_addr=2 reads 9'h16E, then 0.
  - Write addr 0x20 data 9'h1FF: shadow unchanged, cs pulse still issued.
- Fast master: spi_rdy never drops low.
  - Expect the timeout path after 4 cycles, cs pulse, busy cleared, no hang.
  - Request during busy: grant is issued only after GAP.
- Withdraw and reset mid-operation:
  - req[1] dropped before grant: no gnt[1], no transfer.
  - reset=0 during LATCH: cs=1 asynchronously, wr_count=0, shadow cleared; next request after release is served normally.
- Wrap: 256 writes -> wr_count returns to 0.
